// File: rtl/tracker_ctrl.sv
// tracker_ctrl -- line-follower motor controller.
//
// Three raw IR line sensors are synchronized and debounced, decoded into a
// steering target, and fed to a small FSM that drives two motor commands.
// Turn states are held for a minimum time so the robot commits to a turn.
// A reverse search is bounded in time, after which the robot halts until
// the run enable is dropped.
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   en      in   run enable, 0 forces IDLE
//   sensor  in   [2:0] raw {left, mid, right}, 1 = line seen, async to clk
//   l_mode  out  [1:0] left motor: 0 stop, 1 forward, 2 reverse
//   r_mode  out  [1:0] right motor, same encoding
//   state   out  [2:0] FSM state code (debug)

// Per-bit synchronizer + debounce filter.
//   clk, rst  clock / async reset
//   raw       asynchronous input bit
//   filt      debounced output bit
module tracker_deb_lane #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filt
);
   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // cnt counts consecutive cycles where sync[1] disagrees with filt; the
   // update happens on the DEB_CYCLES-th disagreeing cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         filt <= 1'b0;
         cnt  <= '0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            filt <= sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module tracker_ctrl #(
   parameter int DEB_CYCLES  = 16,
   parameter int HOLD_CYCLES = 1000,
   parameter int LOST_CYCLES = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [2:0] sensor,
   output logic [1:0] l_mode,
   output logic [1:0] r_mode,
   output logic [2:0] state
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FWD   = 3'd1,
      S_LEFT  = 3'd2,
      S_RIGHT = 3'd3,
      S_LOST  = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] LOST_LAST = 32'(LOST_CYCLES - 1);

   state_t      state_q, state_d, tgt;
   logic        keep;
   logic [2:0]  filt;
   logic [31:0] hold_cnt, lost_cnt;

   for (genvar i = 0; i < 3; i++) begin : g_lane
      tracker_deb_lane #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk  (clk),
         .rst  (rst),
         .raw  (sensor[i]),
         .filt (filt[i])
      );
   end

   // Steering target from filtered {L,M,R}; 101 is ambiguous and keeps
   // whatever the FSM is currently doing.
   always_comb begin
      tgt  = S_LOST;
      keep = 1'b0;
      case (filt)
         3'b010, 3'b111: tgt = S_FWD;
         3'b100, 3'b110: tgt = S_LEFT;
         3'b001, 3'b011: tgt = S_RIGHT;
         3'b000:         tgt = S_LOST;
         default:        keep = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  state_d = keep ? S_FWD : tgt;
            S_FWD:   if (!keep) state_d = tgt;
            S_LEFT,
            S_RIGHT: if (hold_cnt == '0 && !keep) state_d = tgt;
            S_LOST: begin
               if (!keep && tgt != S_LOST)  state_d = tgt;
               else if (lost_cnt >= LOST_LAST) state_d = S_HALT;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // hold_cnt: loaded on turn entry, counts down to 0 where leaving is allowed.
   // lost_cnt: cycles already spent in LOST, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         lost_cnt <= '0;
      end else begin
         if ((state_d == S_LEFT || state_d == S_RIGHT) && state_d != state_q)
            hold_cnt <= HOLD_LOAD;
         else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - 32'd1;

         if (state_d == S_LOST && state_q != S_LOST)
            lost_cnt <= '0;
         else if (state_q == S_LOST && lost_cnt != '1)
            lost_cnt <= lost_cnt + 32'd1;
      end
   end

   always_comb begin
      l_mode = 2'd0;
      r_mode = 2'd0;
      case (state_q)
         S_FWD:   begin l_mode = 2'd1; r_mode = 2'd1; end
         S_LEFT:  begin l_mode = 2'd2; r_mode = 2'd1; end
         S_RIGHT: begin l_mode = 2'd1; r_mode = 2'd2; end
         S_LOST:  begin l_mode = 2'd2; r_mode = 2'd2; end
         default: begin l_mode = 2'd0; r_mode = 2'd0; end
      endcase
   end

   assign state = state_q;
endmodule

// File: tb/tb_tracker_ctrl.sv
// Self-checking bench for tracker_ctrl (DEB=4, HOLD=8, LOST=20).
module tb_tracker_ctrl;
   localparam int DEB   = 4;
   localparam int HOLD  = 8;
   localparam int LOSTC = 20;

   logic       clk = 1'b0;
   logic       rst, en;
   logic [2:0] sensor;
   logic [1:0] l_mode, r_mode;
   logic [2:0] state;

   tracker_ctrl #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .LOST_CYCLES(LOSTC)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .sensor (sensor),
      .l_mode (l_mode),
      .r_mode (r_mode),
      .state  (state)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: sensor delay line, run-length of disagreement per bit,
   // and time-in-state for the FSM.
   logic [2:0] m_s1, m_s2, m_filt;
   int         m_run [3];
   int         m_st, m_tin;

   function automatic int tgt_of(input logic [2:0] f);
      case (f)
         3'b010, 3'b111: return 1;
         3'b100, 3'b110: return 2;
         3'b001, 3'b011: return 3;
         3'b000:         return 4;
         default:        return -1;
      endcase
   endfunction

   function automatic logic [3:0] modes_of(input int st);
      case (st)
         1:       return 4'b01_01;
         2:       return 4'b10_01;
         3:       return 4'b01_10;
         4:       return 4'b10_10;
         default: return 4'b00_00;
      endcase
   endfunction

   function void model_reset();
      m_s1 = '0; m_s2 = '0; m_filt = '0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      m_st = 0; m_tin = 1;
   endfunction

   function void model_step(input logic e, input logic [2:0] s);
      int t, nxt;
      t = tgt_of(m_filt);
      if (!e) nxt = 0;
      else begin
         case (m_st)
            0, 1:    nxt = (t < 0) ? 1 : t;
            2, 3:    nxt = (m_tin >= HOLD && t >= 0) ? t : m_st;
            4: begin
               if (t >= 0 && t != 4)  nxt = t;
               else if (m_tin >= LOSTC) nxt = 5;
               else                   nxt = 4;
            end
            default: nxt = m_st;
         endcase
      end
      if (nxt != m_st) begin m_st = nxt; m_tin = 1; end
      else m_tin++;
      for (int b = 0; b < 3; b++) begin
         if (m_s2[b] != m_filt[b]) begin
            m_run[b]++;
            if (m_run[b] == DEB) begin m_filt[b] = m_s2[b]; m_run[b] = 0; end
         end else m_run[b] = 0;
      end
      m_s2 = m_s1;
      m_s1 = s;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: model advances with the inputs the DUT sampled, then the
   // whole output vector {state,l_mode,r_mode} is compared.
   task automatic tick();
      @(posedge clk);
      model_step(en, sensor);
      #1;
      check("model", int'({state, l_mode, r_mode}), int'({3'(m_st), modes_of(m_st)}));
   endtask

   typedef struct {
      logic       en;
      logic [2:0] sen;
      int         n;
      int         st;
   } vec_t;
   vec_t vt [26];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0]  = '{1'b1, 3'b010, 6,  4};  // out of reset filtered=000 -> LOST
      vt[1]  = '{1'b1, 3'b010, 1,  1};  // FWD exactly 7 edges after first sample
      vt[2]  = '{1'b1, 3'b100, 3,  1};  // short glitch
      vt[3]  = '{1'b1, 3'b010, 10, 1};  //   ignored
      vt[4]  = '{1'b1, 3'b100, 6,  1};
      vt[5]  = '{1'b1, 3'b100, 1,  2};  // LEFT entry
      vt[6]  = '{1'b1, 3'b100, 1,  2};
      vt[7]  = '{1'b1, 3'b010, 6,  2};  // 7 cycles into LEFT, still held
      vt[8]  = '{1'b1, 3'b010, 1,  1};  // 8th edge leaves
      vt[9]  = '{1'b1, 3'b001, 7,  3};  // RIGHT entry
      vt[10] = '{1'b1, 3'b010, 7,  3};  // target FWD ready but hold blocks
      vt[11] = '{1'b1, 3'b010, 1,  1};
      vt[12] = '{1'b1, 3'b101, 10, 1};  // ambiguous keeps FWD
      vt[13] = '{1'b1, 3'b111, 10, 1};
      vt[14] = '{1'b1, 3'b000, 7,  4};  // LOST entry
      vt[15] = '{1'b1, 3'b000, 19, 4};
      vt[16] = '{1'b1, 3'b000, 1,  5};  // 20 cycles of LOST -> HALT
      vt[17] = '{1'b1, 3'b010, 10, 5};  // HALT ignores sensors
      vt[18] = '{1'b0, 3'b010, 1,  0};
      vt[19] = '{1'b1, 3'b010, 1,  1};
      vt[20] = '{1'b1, 3'b100, 7,  2};
      vt[21] = '{1'b1, 3'b100, 2,  2};
      vt[22] = '{1'b0, 3'b100, 1,  0};  // en drop overrides hold
      vt[23] = '{1'b1, 3'b100, 1,  2};
      vt[24] = '{1'b1, 3'b000, 8,  4};
      vt[25] = '{1'b1, 3'b000, 3,  4};

      rst = 1'b1; en = 1'b0; sensor = 3'b000;
      #22;
      check("reset_state", int'(state), 0);
      check("reset_modes", int'({l_mode, r_mode}), 0);
      model_reset();
      rst = 1'b0;

      for (int i = 0; i < 26; i++) begin
         en = vt[i].en;
         sensor = vt[i].sen;
         repeat (vt[i].n) tick();
         check($sformatf("vec%0d_state", i), int'(state), vt[i].st);
         check($sformatf("vec%0d_modes", i), int'({l_mode, r_mode}), int'(modes_of(vt[i].st)));
      end

      // Asynchronous reset pulse between edges while in LOST.
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_state", int'(state), 0);
      check("async_rst_modes", int'({l_mode, r_mode}), 0);
      model_reset();
      #1;
      rst = 1'b0;

      // Randomized segments against the model.
      for (int seg = 0; seg < 400; seg++) begin
         en = ($urandom_range(0, 15) != 0);
         sensor = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) sensor = 3'b000;
         repeat ($urandom_range(1, 14)) tick();
         if ($urandom_range(0, 7) == 0) begin
            sensor = 3'b000;
            repeat (30) tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/tracker_ctrl.md
TRACKER_CTRL -- requirements
Module: tracker_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, stable cycles required before a sensor bit change is accepted (>=1).
REQ-002 SHALL have parameter HOLD_CYCLES, default 1000, minimum clk cycles spent in a turn state (>=1).
REQ-003 SHALL have parameter LOST_CYCLES, default 5000000, maximum clk cycles of reverse search before halting (>=1).
REQ-004 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port en  input  1  run enable; 0 forces stop.
REQ-007 SHALL have port sensor  input  3  raw IR line sensors {left, mid, right}, 1 = line detected, asynchronous to clk.
REQ-008 SHALL have port l_mode  output  2  left motor command: 0 stop, 1 forward, 2 reverse.
REQ-009 SHALL have port r_mode  output  2  right motor command, same encoding.
REQ-010 SHALL have port state  output  3  current FSM state code, for debug.

Function
REQ-011 SHALL pass each sensor bit through a 2-flop synchronizer.
REQ-012 SHALL update each filtered bit to its synchronized value only after the two have differed for DEB_CYCLES consecutive cycles; any cycle of equality clears that bit's counter.
REQ-013 SHALL decode filtered {L,M,R}: 010 or 111 -> FWD; 100 or 110 -> LEFT; 001 or 011 -> RIGHT; 000 -> LOST; 101 -> no change (keep current target; FWD if leaving IDLE).
REQ-014 SHALL implement states IDLE=0, FWD=1, LEFT=2, RIGHT=3, LOST=4, HALT=5; codes 6-7 unreachable and SHALL recover to IDLE.
REQ-015 SHALL drive outputs as a pure decode of the state register: IDLE/HALT (0,0); FWD (1,1); LEFT (2,1); RIGHT (1,2); LOST (2,2); value 3 never driven.
REQ-016 SHALL, with en=0, enter IDLE on the next edge from any state, overriding hold and lost timers.
REQ-017 SHALL, in IDLE with en=1, move to the decoded target on the next edge.
REQ-018 SHALL, in FWD, move to the decoded target on the next edge whenever it differs.
REQ-019 SHALL, on entering LEFT or RIGHT, load a hold counter and remain in that state for at least HOLD_CYCLES cycles; afterwards move to the decoded target on the next edge.
REQ-020 SHALL, on entering LOST, clear a saturating lost counter; leave LOST to the decoded target as soon as it is not LOST; enter HALT when the counter reaches LOST_CYCLES.
REQ-021 SHALL remain in HALT regardless of sensor until en=0 (then IDLE).
REQ-022 SHALL reach the decoded outputs exactly DEB_CYCLES+3 rising edges after a stable sensor change is first sampled (2 sync + DEB_CYCLES filter + 1 FSM), absent hold or en effects.
REQ-023 SHALL size hold and lost counters to 32 bits, never wrapping.
REQ-024 SHALL treat a sensor change shorter than DEB_CYCLES cycles as absent.

Reset
REQ-025 SHALL, while rst=1, force state=IDLE, l_mode=0, r_mode=0, synchronizer, filtered bits and all counters to 0, independent of clk.
REQ-026 SHALL, after rst release with en=1 and filtered=000, enter LOST (decoded target), not FWD.

Verification (DEB_CYCLES=4, HOLD_CYCLES=8, LOST_CYCLES=20)
REQ-027 SHALL cover: rst, en=1, sensor=010 held -> (l_mode,r_mode)=(1,1), state=1, exactly 7 edges after first sampling 010.
REQ-028 SHALL cover: in FWD, sensor 100 for 3 cycles then back to 010 -> outputs stay (1,1) throughout.
REQ-029 SHALL cover: in FWD, sensor 100 held -> (2,1); switch to 010 two cycles after LEFT entry -> stays (2,1) until 8 cycles in LEFT, then (1,1).
REQ-030 SHALL cover: in FWD, sensor 000 held -> (2,2) for 20 cycles then (0,0), state=5; then sensor 010 -> stays HALT; en 1->0->1 -> IDLE then FWD.
REQ-031 SHALL cover: en=0 mid-LEFT hold -> (0,0), state=0 on next edge; rst pulse mid-LOST between edges -> (0,0), state=0 immediately.
REQ-032 SHALL cover: in FWD, sensor 101 held -> remains FWD (1,1); sensor 111 -> FWD.
